// File: rtl/sample_capture_pkg.sv
// Shared encodings for the sample capture block: FSM state codes and trigger modes.
package sample_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } cap_state_e;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'b00,
    TRIG_RISING    = 2'b01,
    TRIG_FALLING   = 2'b10,
    TRIG_EXTERNAL  = 2'b11
  } trig_mode_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Deliberately has no reset so it maps onto block RAM.
module capture_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Synchronous write and read; the read register only loads on a pop.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_capture.sv
// Triggered capture of decimated samples into a buffer, followed by in-order readout.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_ce,
  input  logic              arm,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              ext_trig,
  input  logic [ADDR_W:0]   capture_len,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   wr_count
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  cap_state_e               state_q, state_d;
  trig_mode_e               mode_q, mode_d;
  logic signed [DATA_W-1:0] level_q, level_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic [ADDR_W:0]          wr_count_q, wr_count_d;
  logic [ADDR_W:0]          rd_ptr_q, rd_ptr_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]        hold_q, hold_d;

  logic signed [DATA_W-1:0] cur;
  logic [ADDR_W:0]          eff_len;
  logic [ADDR_W:0]          wr_next;
  logic                     do_arm;
  logic                     trigger;
  logic                     ram_we;
  logic                     ram_re;
  logic [ADDR_W-1:0]        ram_waddr;
  logic [DATA_W-1:0]        ram_rdata;

  assign cur     = sample_in;
  assign eff_len = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;
  assign wr_next = wr_count_q + 1'b1;

  // Next-state logic: arming, trigger detection, buffer writes and readout pops.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    level_d      = level_q;
    len_d        = len_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_count_d   = wr_count_q;
    rd_ptr_d     = rd_ptr_q;
    rd_valid_d   = 1'b0;
    hold_d       = rd_valid_q ? ram_rdata : hold_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_waddr    = wr_count_q[ADDR_W-1:0];
    do_arm       = arm && (state_q != ST_CAPTURE);

    case (mode_q)
      TRIG_IMMEDIATE: trigger = 1'b1;
      TRIG_RISING:    trigger = prev_valid_q && (prev_q < level_q) && (cur >= level_q);
      TRIG_FALLING:   trigger = prev_valid_q && (prev_q > level_q) && (cur <= level_q);
      TRIG_EXTERNAL:  trigger = ext_trig;
      default:        trigger = 1'b0;
    endcase

    if (do_arm) begin
      state_d      = ST_ARMED;
      mode_d       = trig_mode_e'(trig_mode);
      level_d      = trig_level;
      len_d        = eff_len;
      prev_d       = '0;
      prev_valid_d = 1'b0;
      wr_count_d   = '0;
      rd_ptr_d     = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sample_ce) begin
            prev_d       = cur;
            prev_valid_d = 1'b1;
            if (trigger) begin
              ram_we     = 1'b1;
              wr_count_d = wr_next;
              state_d    = (wr_next == len_q) ? ST_DONE : ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (sample_ce) begin
            ram_we     = 1'b1;
            wr_count_d = wr_next;
            if (wr_next == len_q) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (rd_valid_q && rd_ptr_q == len_q) begin
            state_d    = ST_IDLE;
            wr_count_d = '0;
            rd_ptr_d   = '0;
          end else if (rd_en && rd_ptr_q != len_q) begin
            ram_re     = 1'b1;
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset abandons any capture in progress.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= TRIG_IMMEDIATE;
      level_q      <= '0;
      len_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_count_q   <= '0;
      rd_ptr_q     <= '0;
      rd_valid_q   <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      level_q      <= level_d;
      len_q        <= len_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_count_q   <= wr_count_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_valid_q   <= rd_valid_d;
      hold_q       <= hold_d;
    end
  end

  capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (sys_clk),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(sample_in),
    .rd_en  (ram_re),
    .rd_addr(rd_ptr_q[ADDR_W-1:0]),
    .rd_data(ram_rdata)
  );

  assign rd_data  = rd_valid_q ? ram_rdata : hold_q;
  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_sample_capture;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_ce = 1'b0;
  logic              arm = 1'b0;
  logic [1:0]        trig_mode = '0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              ext_trig = 1'b0;
  logic [ADDR_W:0]   capture_len = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [1:0]        state;
  logic [ADDR_W:0]   wr_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [DATA_W-1:0] popped[$];
  logic [DATA_W-1:0] stim_q[$];
  logic [DATA_W-1:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  sample_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .sample_in  (sample_in),
    .sample_ce  (sample_ce),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .ext_trig   (ext_trig),
    .capture_len(capture_len),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .state      (state),
    .wr_count   (wr_count)
  );

  // Behavioural model: the capture is a queue, readout an index into it.
  int                m_state = S_IDLE;
  int                m_mode = 0;
  int                m_level = 0;
  int                m_len = 0;
  int                m_prev = 0;
  bit                m_prev_ok = 1'b0;
  int                m_rd_idx = 0;
  bit                m_rd_valid = 1'b0;
  logic [DATA_W-1:0] m_rd_data = '0;
  logic [DATA_W-1:0] m_buf[$];

  function automatic int effLen(input logic [ADDR_W:0] len);
    if (len == 0 || int'(len) > DEPTH) return DEPTH;
    return int'(len);
  endfunction

  task automatic modelStep();
    int cur;
    bit trig;
    bit popped_now;
    cur = int'($signed(sample_in));
    popped_now = 1'b0;
    trig = 1'b0;
    if (arm && m_state != S_CAPTURE) begin
      m_state = S_ARMED;
      m_mode = int'(trig_mode);
      m_level = int'($signed(trig_level));
      m_len = effLen(capture_len);
      m_prev_ok = 1'b0;
      m_buf.delete();
      m_rd_idx = 0;
    end else if (m_state == S_ARMED && sample_ce) begin
      case (m_mode)
        0: trig = 1'b1;
        1: trig = m_prev_ok && m_prev < m_level && cur >= m_level;
        2: trig = m_prev_ok && m_prev > m_level && cur <= m_level;
        default: trig = ext_trig;
      endcase
      m_prev = cur;
      m_prev_ok = 1'b1;
      if (trig) begin
        m_buf.push_back(sample_in);
        m_state = (m_buf.size() == m_len) ? S_DONE : S_CAPTURE;
      end
    end else if (m_state == S_CAPTURE && sample_ce) begin
      m_buf.push_back(sample_in);
      if (m_buf.size() == m_len) m_state = S_DONE;
    end else if (m_state == S_DONE) begin
      if (m_rd_valid && m_rd_idx == m_buf.size()) begin
        m_state = S_IDLE;
        m_buf.delete();
        m_rd_idx = 0;
      end else if (rd_en && m_rd_idx < m_buf.size()) begin
        m_rd_data = m_buf[m_rd_idx];
        m_rd_idx++;
        popped_now = 1'b1;
      end
    end
    m_rd_valid = popped_now;
  endtask

  // Model advances on the same edge as the DUT; reset clears everything but the RAM.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = S_IDLE;
      m_mode = 0;
      m_level = 0;
      m_len = 0;
      m_prev_ok = 1'b0;
      m_buf.delete();
      m_rd_idx = 0;
      m_rd_valid = 1'b0;
      m_rd_data = '0;
    end else begin
      modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge sys_clk) begin
    if (cmp_en) begin
      checkOutput("state", 32'(state), 32'(m_state));
      checkOutput("wr_count", 32'(wr_count),
                  (m_state == S_CAPTURE || m_state == S_DONE) ? 32'(m_buf.size()) : 32'd0);
      checkOutput("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      checkOutput("rd_data", 32'(rd_data), 32'(m_rd_data));
      if (rd_valid) popped.push_back(rd_data);
    end
  end

  task automatic applyStimulus(input bit ce, input logic [DATA_W-1:0] smp, input bit a,
                               input bit rd, input bit ext);
    sample_ce = ce;
    sample_in = smp;
    arm = a;
    rd_en = rd;
    ext_trig = ext;
    @(negedge sys_clk);
  endtask

  task automatic armWith(input int mode, input int level, input int len);
    trig_mode = 2'(mode);
    trig_level = 16'(level);
    capture_len = 11'(len);
    applyStimulus(1'b0, 16'($urandom), 1'b1, 1'b0, 1'b0);
    trig_mode = 2'($urandom);
    trig_level = 16'($urandom);
    capture_len = 11'($urandom);
  endtask

  task automatic feedSamples(input int gap);
    foreach (stim_q[i]) begin
      repeat (gap - 1) applyStimulus(1'b0, 16'($urandom), 1'b0, 1'b0, 1'($urandom));
      applyStimulus(1'b1, stim_q[i], 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drainAll(input int budget);
    int n;
    n = 0;
    popped.delete();
    while (state != 2'd0 && n < budget) begin
      applyStimulus(1'b0, 16'($urandom), 1'b0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("drain_reaches_idle", 32'(state), 32'd0);
  endtask

  task automatic checkPopped(input string name);
    checkOutput({name, "_count"}, 32'(popped.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < popped.size()) checkOutput(name, 32'(popped[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    cmp_en = 1'b1;
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_wr_count", 32'(wr_count), 32'd0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_rd_ignored", 32'(rd_valid), 32'd0);

    $display("[TB] immediate trigger, length 4");
    armWith(0, 0, 4);
    stim_q = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    feedSamples(1);
    checkOutput("imm_done_state", 32'(state), 32'd3);
    checkOutput("imm_done_count", 32'(wr_count), 32'd4);
    drainAll(20);
    exp_q = '{16'd10, 16'd20, 16'd30, 16'd40};
    checkPopped("imm_readout");
    checkOutput("imm_idle_count", 32'(wr_count), 32'd0);

    $display("[TB] rising crossing, level 0, length 3");
    armWith(1, 0, 3);
    stim_q = '{16'hFFFB, 16'hFFFF, 16'd0, 16'd7, 16'd9, 16'd3};
    feedSamples(1);
    checkOutput("rise_done_count", 32'(wr_count), 32'd3);
    drainAll(20);
    exp_q = '{16'd0, 16'd7, 16'd9};
    checkPopped("rise_readout");

    $display("[TB] falling crossing, level 100, length 2, sparse strobe");
    armWith(2, 100, 2);
    stim_q = '{16'd200, 16'd150, 16'd100, 16'd50};
    feedSamples(4);
    checkOutput("fall_done_state", 32'(state), 32'd3);
    drainAll(20);
    exp_q = '{16'd100, 16'd50};
    checkPopped("fall_readout");

    $display("[TB] external trigger, length 0 means full depth");
    armWith(3, 0, 0);
    checkOutput("model_len_full", 32'(m_len), 32'(DEPTH));
    exp_q.delete();
    for (int k = 0; k < 1031; k++) begin
      applyStimulus(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 16'(k * 37 + 5), 1'b0, 1'b0, k == 4);
      if (k >= 4 && k < 4 + DEPTH) exp_q.push_back(16'(k * 37 + 5));
    end
    checkOutput("ext_done_state", 32'(state), 32'd3);
    checkOutput("ext_done_count", 32'(wr_count), 32'd1024);
    drainAll(1100);
    checkPopped("ext_readout");
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("ext_extra_pop", 32'(rd_valid), 32'd0);

    $display("[TB] arm during capture, arm with read in done, reset mid-capture");
    armWith(0, 0, 6);
    stim_q = '{16'd1, 16'd2};
    feedSamples(1);
    applyStimulus(1'b1, 16'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("arm_in_capture_state", 32'(state), 32'd2);
    checkOutput("arm_in_capture_count", 32'(wr_count), 32'd3);
    stim_q = '{16'd4, 16'd5, 16'd6};
    feedSamples(1);
    checkOutput("capture6_count", 32'(wr_count), 32'd6);
    trig_mode = 2'd0;
    capture_len = 11'd5;
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("arm_rd_state", 32'(state), 32'd1);
    checkOutput("arm_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b1, 16'd77, 1'b0, 1'b0, 1'b0);
    checkOutput("rearm_capture_count", 32'(wr_count), 32'd1);
    #2 rst_n = 1'b0;
    @(negedge sys_clk);
    checkOutput("midcap_reset_state", 32'(state), 32'd0);
    checkOutput("midcap_reset_count", 32'(wr_count), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge sys_clk);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("post_reset_rd", 32'(rd_valid), 32'd0);

    $display("[TB] randomized soak");
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      trig_mode = 2'($urandom);
      trig_level = 16'(int'($urandom_range(0, 8)) - 4);
      if (r < 2) capture_len = 11'd0;
      else if (r < 4) capture_len = 11'(1025 + $urandom_range(0, 1022));
      else capture_len = 11'($urandom_range(1, 12));
      applyStimulus(1'($urandom), 16'(int'($urandom_range(0, 16)) - 8),
                    $urandom_range(0, 39) == 0, 1'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
